// File: rtl/feed_msg_arbiter.sv
// Round-robin, message-atomic merge of several feed_decoder Avalon-ST streams onto one bus.
// A beat watchdog truncates runaway messages; orphan non-SOP beats from other feeds are drained.
module feed_msg_arbiter #(
    parameter int unsigned C_NUM_FEEDS       = 4,
    parameter int unsigned C_PKT_BEAT_BYTES  = 8,
    parameter int unsigned C_MSG_MAX_BEATS   = 4,
    parameter int unsigned C_PKT_DATA_WIDTH  = C_PKT_BEAT_BYTES * 8,
    parameter int unsigned C_PKT_EMPTY_WIDTH = $clog2(C_PKT_BEAT_BYTES),
    parameter int unsigned C_ID_WIDTH        = $clog2(C_NUM_FEEDS)
) (
    input  logic                                       clk,
    input  logic                                       reset_n,

    output logic [C_NUM_FEEDS-1:0]                     in_ready,
    input  logic [C_NUM_FEEDS-1:0]                     in_valid,
    input  logic [C_NUM_FEEDS-1:0]                     in_startofpacket,
    input  logic [C_NUM_FEEDS-1:0]                     in_endofpacket,
    input  logic [C_NUM_FEEDS*C_PKT_DATA_WIDTH-1:0]    in_data,
    input  logic [C_NUM_FEEDS*C_PKT_EMPTY_WIDTH-1:0]   in_empty,
    input  logic [C_NUM_FEEDS-1:0]                     in_error,

    input  logic                                       out_ready,
    output logic                                       out_valid,
    output logic                                       out_startofpacket,
    output logic                                       out_endofpacket,
    output logic                                       out_error,
    output logic [C_PKT_DATA_WIDTH-1:0]                out_data,
    output logic [C_PKT_EMPTY_WIDTH-1:0]               out_empty,
    output logic [C_ID_WIDTH-1:0]                      out_feed_id,

    output logic [15:0]                                drop_cnt,
    output logic [15:0]                                trunc_cnt
);

    localparam int unsigned CNT_WIDTH      = $clog2(C_MSG_MAX_BEATS + 1);
    localparam int unsigned DROP_SUM_WIDTH = $clog2(C_NUM_FEEDS + 1);

    typedef enum logic [0:0] {
        StIdle,
        StLocked
    } state_e;

    state_e                  state_q;
    logic [C_ID_WIDTH-1:0]   grant_q;
    logic [C_ID_WIDTH-1:0]   last_grant_q;
    logic [CNT_WIDTH-1:0]    beat_cnt_q;

    logic                         load_en;
    logic [C_NUM_FEEDS-1:0]       eligible;
    logic [C_NUM_FEEDS-1:0]       orphan;
    logic                         pick_found;
    logic [C_ID_WIDTH-1:0]        pick_id;
    logic [C_ID_WIDTH-1:0]        sel_id;
    logic [C_PKT_DATA_WIDTH-1:0]  sel_data;
    logic [C_PKT_EMPTY_WIDTH-1:0] sel_empty;
    logic                         sel_sop;
    logic                         sel_eop;
    logic                         sel_err;
    logic                         accept;
    logic                         sop_restart;
    logic                         trunc;
    logic [CNT_WIDTH-1:0]         acc_idx;
    logic [DROP_SUM_WIDTH-1:0]    drop_beats;
    logic [16:0]                  drop_sum;
    logic [15:0]                  drop_next;

    assign load_en  = !out_valid || out_ready;
    assign eligible = in_valid & in_startofpacket;

    // Round-robin scan starting just after the most recent grant.
    always_comb begin
        int unsigned idx;
        logic [C_ID_WIDTH-1:0] cand;
        pick_found = 1'b0;
        pick_id    = '0;
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 0; k < C_NUM_FEEDS; k++) begin
            idx  = (32'(last_grant_q) + 32'd1 + k) % C_NUM_FEEDS;
            cand = C_ID_WIDTH'(idx);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    assign sel_id    = (state_q == StIdle) ? pick_id : grant_q;
    assign sel_data  = in_data[sel_id*C_PKT_DATA_WIDTH +: C_PKT_DATA_WIDTH];
    assign sel_empty = in_empty[sel_id*C_PKT_EMPTY_WIDTH +: C_PKT_EMPTY_WIDTH];
    assign sel_sop   = in_startofpacket[sel_id];
    assign sel_eop   = in_endofpacket[sel_id];
    assign sel_err   = in_error[sel_id];

    assign accept = (state_q == StIdle) ? (pick_found && load_en)
                                        : (load_en && in_valid[grant_q]);

    // A fresh SOP on the locked feed closes the open message and restarts the count.
    assign sop_restart = (state_q == StLocked) && sel_sop;
    assign acc_idx     = ((state_q == StIdle) || sel_sop) ? CNT_WIDTH'(1)
                                                          : beat_cnt_q + CNT_WIDTH'(1);
    assign trunc       = accept && !sel_eop && (acc_idx == CNT_WIDTH'(C_MSG_MAX_BEATS));

    always_comb begin
        orphan = '0;
        for (int unsigned i = 0; i < C_NUM_FEEDS; i++) begin
            orphan[i] = in_valid[i] && !in_startofpacket[i] &&
                        !((state_q == StLocked) && (grant_q == C_ID_WIDTH'(i)));
        end
    end

    always_comb begin
        in_ready = orphan;
        if (state_q == StIdle) begin
            if (pick_found && load_en) begin
                in_ready[pick_id] = 1'b1;
            end
        end else begin
            in_ready[grant_q] = load_en;
        end
    end

    always_comb begin
        drop_beats = '0;
        for (int unsigned i = 0; i < C_NUM_FEEDS; i++) begin
            drop_beats = drop_beats + DROP_SUM_WIDTH'(orphan[i]);
        end
    end

    assign drop_sum  = {1'b0, drop_cnt} + 17'(drop_beats);
    assign drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= StIdle;
            grant_q           <= '0;
            last_grant_q      <= C_ID_WIDTH'(C_NUM_FEEDS - 1);
            beat_cnt_q        <= '0;
            out_valid         <= 1'b0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_error         <= 1'b0;
            out_data          <= '0;
            out_empty         <= '0;
            out_feed_id       <= '0;
            drop_cnt          <= '0;
            trunc_cnt         <= '0;
        end else begin
            drop_cnt <= drop_next;
            if (trunc && (trunc_cnt != 16'hFFFF)) begin
                trunc_cnt <= trunc_cnt + 16'd1;
            end

            if (load_en) begin
                out_valid <= accept;
            end

            if (accept) begin
                out_data          <= sel_data;
                out_empty         <= trunc ? '0 : sel_empty;
                out_startofpacket <= sel_sop;
                out_endofpacket   <= sel_eop || trunc;
                out_error         <= sel_err || trunc || sop_restart;
                out_feed_id       <= sel_id;

                grant_q <= sel_id;
                if (state_q == StIdle) begin
                    last_grant_q <= pick_id;
                end
                if (sel_eop || trunc) begin
                    state_q    <= StIdle;
                    beat_cnt_q <= '0;
                end else begin
                    state_q    <= StLocked;
                    beat_cnt_q <= acc_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_feed_msg_arbiter.sv
// Scoreboard bench for feed_msg_arbiter: queued per-feed sources, expected-beat queue,
// per-scenario tasks with inline checks.
module tb_feed_msg_arbiter;

    localparam int NF   = 4;
    localparam int W    = 64;
    localparam int E    = 3;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [W-1:0] data;
        logic [E-1:0] empty;
        logic         sop;
        logic         eop;
        logic         err;
    } src_beat_t;

    typedef struct packed {
        logic [W-1:0]   data;
        logic [E-1:0]   empty;
        logic           sop;
        logic           eop;
        logic           err;
        logic [IDW-1:0] id;
    } exp_beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [NF-1:0]     in_ready;
    logic [NF-1:0]     in_valid = '0;
    logic [NF-1:0]     in_startofpacket = '0;
    logic [NF-1:0]     in_endofpacket = '0;
    logic [NF*W-1:0]   in_data = '0;
    logic [NF*E-1:0]   in_empty = '0;
    logic [NF-1:0]     in_error = '0;
    logic              out_ready = 1'b1;
    logic              out_valid;
    logic              out_startofpacket;
    logic              out_endofpacket;
    logic              out_error;
    logic [W-1:0]      out_data;
    logic [E-1:0]      out_empty;
    logic [IDW-1:0]    out_feed_id;
    logic [15:0]       drop_cnt;
    logic [15:0]       trunc_cnt;

    feed_msg_arbiter #(
        .C_NUM_FEEDS     (NF),
        .C_PKT_BEAT_BYTES(8),
        .C_MSG_MAX_BEATS (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_ready         (in_ready),
        .in_valid         (in_valid),
        .in_startofpacket (in_startofpacket),
        .in_endofpacket   (in_endofpacket),
        .in_data          (in_data),
        .in_empty         (in_empty),
        .in_error         (in_error),
        .out_ready        (out_ready),
        .out_valid        (out_valid),
        .out_startofpacket(out_startofpacket),
        .out_endofpacket  (out_endofpacket),
        .out_error        (out_error),
        .out_data         (out_data),
        .out_empty        (out_empty),
        .out_feed_id      (out_feed_id),
        .drop_cnt         (drop_cnt),
        .trunc_cnt        (trunc_cnt)
    );

    always #5 clk = ~clk;

    src_beat_t src_q[NF][$];
    exp_beat_t exp_q[$];
    bit        rdy_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_xfer = 0;
    int first_xfer = 0;
    int last_xfer = 0;
    int exp_drop = 0;
    int exp_trunc = 0;
    bit run = 1'b0;

    // Drive inputs at negedge, then record accepted inputs and transferred outputs.
    always @(negedge clk) begin
        cyc++;
        if (!run) begin
            in_valid = '0;
            in_startofpacket = '0;
            in_endofpacket = '0;
            in_error = '0;
            out_ready = 1'b1;
        end else begin
            out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
            for (int f = 0; f < NF; f++) begin
                if (src_q[f].size() > 0) begin
                    in_valid[f]         = 1'b1;
                    in_startofpacket[f] = src_q[f][0].sop;
                    in_endofpacket[f]   = src_q[f][0].eop;
                    in_error[f]         = src_q[f][0].err;
                    in_data[f*W +: W]   = src_q[f][0].data;
                    in_empty[f*E +: E]  = src_q[f][0].empty;
                end else begin
                    in_valid[f]         = 1'b0;
                    in_startofpacket[f] = 1'b0;
                    in_endofpacket[f]   = 1'b0;
                    in_error[f]         = 1'b0;
                end
            end
            #1;
            for (int f = 0; f < NF; f++) begin
                if (in_valid[f] && in_ready[f]) void'(src_q[f].pop_front());
            end
            if (out_valid && out_ready) begin
                exp_beat_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_beat unexpected: got data=%h id=%0d, required no beat",
                             out_data, out_feed_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_empty, out_startofpacket, out_endofpacket, out_error,
                         out_feed_id} !== e) begin
                        errors++;
                        $display("FAIL out_beat: got data=%h empty=%0d sop=%b eop=%b err=%b id=%0d, required data=%h empty=%0d sop=%b eop=%b err=%b id=%0d",
                                 out_data, out_empty, out_startofpacket, out_endofpacket,
                                 out_error, out_feed_id, e.data, e.empty, e.sop, e.eop,
                                 e.err, e.id);
                    end
                end
                if (n_xfer == 0) first_xfer = cyc;
                last_xfer = cyc;
                n_xfer++;
            end
        end
    end

    task automatic push_msg(input int f, input int tag, input int n, input int err_at);
        src_beat_t s;
        for (int b = 0; b < n; b++) begin
            s.data  = {8'(f), 8'(tag), 16'hC0DE, 32'(b)};
            s.empty = (b == n - 1) ? 3'(f + 1) : 3'd0;
            s.sop   = (b == 0);
            s.eop   = (b == n - 1);
            s.err   = (b == err_at);
            src_q[f].push_back(s);
            exp_q.push_back({s.data, s.empty, s.sop, s.eop, s.err, 2'(f)});
        end
    endtask

    task automatic flush_all();
        exp_q.delete();
        rdy_q.delete();
        for (int f = 0; f < NF; f++) src_q[f].delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int busy;
        int n;
        n = 0;
        busy = 1;
        while (busy != 0 && n < budget) begin
            @(negedge clk);
            #2;
            n++;
            busy = exp_q.size();
            for (int f = 0; f < NF; f++) busy += src_q[f].size();
        end
        if (busy != 0) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: %0d items left after %0d cycles, required 0", name, busy, n);
            flush_all();
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if ({out_valid, out_startofpacket, out_endofpacket, out_error} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000",
                     {out_valid, out_startofpacket, out_endofpacket, out_error});
        end
        checks++;
        if (drop_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got drop=%0d trunc=%0d, required 0 0",
                     drop_cnt, trunc_cnt);
        end
        checks++;
        if (in_ready !== '0) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 0000", in_ready);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_feed_id !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got valid=%b id=%0d, required 0 0",
                     out_valid, out_feed_id);
        end
        run = 1'b1;
    endtask

    task automatic test_round_robin();
        n_xfer = 0;
        for (int f = 0; f < NF; f++) push_msg(f, 1, 3, (f == 2) ? 1 : -1);
        wait_idle("round_robin", 60);
        checks++;
        if (n_xfer != 12 || (last_xfer - first_xfer) != 11) begin
            errors++;
            $display("FAIL rr_no_gaps: got %0d beats over %0d cycles, required 12 over 12",
                     n_xfer, last_xfer - first_xfer + 1);
        end
    endtask

    task automatic test_alternate();
        push_msg(1, 2, 2, -1);
        push_msg(2, 2, 2, -1);
        push_msg(1, 3, 2, -1);
        push_msg(2, 3, 2, -1);
        push_msg(1, 4, 2, -1);
        wait_idle("alternate", 60);
    endtask

    task automatic test_truncation();
        src_beat_t s;
        for (int b = 0; b < 5; b++) begin
            s.data  = {8'd0, 8'd5, 16'hBEEF, 32'(b)};
            s.empty = 3'd5;
            s.sop   = (b == 0);
            s.eop   = 1'b0;
            s.err   = 1'b0;
            src_q[0].push_back(s);
            if (b < 3) exp_q.push_back({s.data, s.empty, s.sop, 1'b0, 1'b0, 2'd0});
            else if (b == 3) exp_q.push_back({s.data, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0});
        end
        exp_trunc += 1;
        exp_drop  += 1;
        wait_idle("truncation", 40);
        checks++;
        if (trunc_cnt !== 16'(exp_trunc)) begin
            errors++;
            $display("FAIL trunc_cnt: got %0d, required %0d", trunc_cnt, exp_trunc);
        end
        checks++;
        if (drop_cnt !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL trunc_drop_cnt: got %0d, required %0d", drop_cnt, exp_drop);
        end
    endtask

    task automatic test_backpressure();
        logic [W+E+IDW+3:0] snap;
        bit stalled_prev;
        bit stalled;
        int nstall;
        stalled_prev = 1'b0;
        nstall = 0;
        snap = '0;
        push_msg(0, 6, 4, -1);
        rdy_q = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            #2;
            stalled = out_valid && !out_ready;
            if (in_valid[0]) begin
                checks++;
                if (in_ready[0] !== !stalled) begin
                    errors++;
                    $display("FAIL bp_in_ready0 cycle %0d: got %b, required %b",
                             c, in_ready[0], !stalled);
                end
            end
            if (stalled_prev) begin
                checks++;
                if ({out_valid, out_startofpacket, out_endofpacket, out_error, out_data,
                     out_empty, out_feed_id} !== snap) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: got %h, required %h", c,
                             {out_valid, out_startofpacket, out_endofpacket, out_error,
                              out_data, out_empty, out_feed_id}, snap);
                end
            end
            if (stalled) nstall++;
            snap = {out_valid, out_startofpacket, out_endofpacket, out_error, out_data,
                    out_empty, out_feed_id};
            stalled_prev = stalled;
        end
        checks++;
        if (nstall < 2) begin
            errors++;
            $display("FAIL bp_stall_seen: got %0d stalled cycles, required at least 2", nstall);
        end
        wait_idle("backpressure", 40);
    endtask

    task automatic test_sop_violation();
        src_beat_t s;
        for (int b = 0; b < 5; b++) begin
            s.data  = {8'd2, 8'd7, 16'hFACE, 32'(b)};
            s.empty = (b == 4) ? 3'd2 : 3'd0;
            s.sop   = (b == 0) || (b == 2);
            s.eop   = (b == 4);
            s.err   = 1'b0;
            src_q[2].push_back(s);
            exp_q.push_back({s.data, s.empty, s.sop, s.eop, (b == 2), 2'd2});
        end
        wait_idle("sop_violation", 40);
    endtask

    task automatic test_orphan();
        src_beat_t s;
        for (int b = 0; b < 2; b++) begin
            s.data  = {8'd3, 8'd8, 16'hDEAD, 32'(b)};
            s.empty = 3'd0;
            s.sop   = 1'b0;
            s.eop   = (b == 1);
            s.err   = 1'b0;
            src_q[3].push_back(s);
        end
        exp_drop += 2;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #2;
            checks++;
            if (in_valid[3] !== 1'b1 || in_ready[3] !== 1'b1) begin
                errors++;
                $display("FAIL orphan_ready beat %0d: got valid=%b ready=%b, required 1 1",
                         c, in_valid[3], in_ready[3]);
            end
        end
        wait_idle("orphan", 20);
        checks++;
        if (drop_cnt !== 16'(exp_drop) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL orphan_drop_cnt: got drop=%0d valid=%b, required drop=%0d valid=0",
                     drop_cnt, out_valid, exp_drop);
        end
    endtask

    task automatic test_reset_mid_message();
        push_msg(1, 9, 4, -1);
        repeat (3) @(negedge clk);
        #2;
        run = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_startofpacket, out_endofpacket, out_error} !== 4'b0 ||
            out_data !== '0 || out_feed_id !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs: got valid=%b data=%h id=%0d, required all 0",
                     out_valid, out_data, out_feed_id);
        end
        checks++;
        if (drop_cnt !== 16'd0 || trunc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL async_reset_counters: got drop=%0d trunc=%0d, required 0 0",
                     drop_cnt, trunc_cnt);
        end
        flush_all();
        in_valid = '0;
        in_startofpacket = '0;
        in_endofpacket = '0;
        exp_drop = 0;
        exp_trunc = 0;
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        @(negedge clk);
        #2;
        run = 1'b1;
        push_msg(0, 10, 2, -1);
        push_msg(2, 10, 2, -1);
        wait_idle("post_reset", 30);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_alternate();
        test_truncation();
        test_backpressure();
        test_sop_violation();
        test_orphan();
        test_reset_mid_message();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

// File: doc/feed_msg_arbiter.md
Name: feed_msg_arbiter

Overview:
Merges the message streams of C_NUM_FEEDS feed_decoder instances onto one Avalon-ST message bus toward order logic. Arbitration is round-robin and message-atomic: a grant is held from the SOP beat to the EOP beat. A beat-count watchdog truncates runaway messages. Orphan (non-SOP) beats from non-granted feeds are drained and counted.

Parameters:
C_NUM_FEEDS, 4, number of feed_decoder streams (2..8)
C_PKT_BEAT_BYTES, 8, bytes per beat
C_MSG_MAX_BEATS, 4, maximum beats per message (32-byte message, byte-0 aligned)
C_PKT_DATA_WIDTH, C_PKT_BEAT_BYTES*8, derived
C_PKT_EMPTY_WIDTH, $clog2(C_PKT_BEAT_BYTES), derived
C_ID_WIDTH, $clog2(C_NUM_FEEDS), derived

Ports:
clk  in  1  clock; single clock domain
reset_n  in  1  reset, asynchronous, active-low
in_ready  out  C_NUM_FEEDS  per-feed ready
in_valid  in  C_NUM_FEEDS  per-feed valid
in_startofpacket  in  C_NUM_FEEDS  per-feed message start
in_endofpacket  in  C_NUM_FEEDS  per-feed message end
in_data  in  C_NUM_FEEDS*C_PKT_DATA_WIDTH  feed i occupies slice [i*W +: W]
in_empty  in  C_NUM_FEEDS*C_PKT_EMPTY_WIDTH  feed i occupies slice [i*E +: E]
in_error  in  C_NUM_FEEDS  per-feed error
out_ready  in  1  downstream ready
out_valid, out_startofpacket, out_endofpacket, out_error  out  1 each  merged stream
out_data  out  C_PKT_DATA_WIDTH  merged data
out_empty  out  C_PKT_EMPTY_WIDTH  merged empty
out_feed_id  out  C_ID_WIDTH  source feed of the current beat
drop_cnt  out  16  orphan beats discarded, saturating
trunc_cnt  out  16  messages truncated by the watchdog, saturating

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; state IDLE; last_grant=C_NUM_FEEDS-1, so feed 0 has first priority; beat_cnt=0.
- Output register: load_en = !out_valid | out_ready. A beat is accepted from feed i when in_valid[i] & in_ready[i]. Accepted beat appears on out_* the next cycle (latency 1). Outputs hold while out_valid & !out_ready.
- Eligible feed: in_valid[i] & in_startofpacket[i].
- IDLE state:
  - Pick the first eligible feed scanning from (last_grant+1) mod N upward with wrap.
  - If a feed is picked and load_en=1: in_ready of that feed is 1 in the same cycle; its SOP beat is accepted; grant=i; last_grant=i; beat_cnt=1.
  - Next state is LOCKED, unless the SOP beat also has EOP, in which case the state stays IDLE.
- LOCKED state:
  - in_ready[grant] = load_en; all other feeds receive no grant.
  - Each accepted beat increments beat_cnt.
  - An accepted EOP beat returns the state to IDLE.
  - Arbitration in the following cycle gives zero output bubble when out_ready stays high.
- Watchdog: if the accepted beat has beat_cnt==C_MSG_MAX_BEATS and no EOP:
  - The beat is output with out_endofpacket=1, out_error=1, out_empty=0.
  - trunc_cnt increments; state returns to IDLE.
  - The remainder of that message is then treated as orphan beats.
- SOP received while LOCKED on the granted feed:
  - The previous message is closed: the new beat is output with out_error=1 and out_startofpacket=1.
  - The grant is held and beat_cnt restarts at 1.
- Orphan drain:
  - Any non-granted feed with in_valid & !in_startofpacket gets in_ready=1 regardless of out_ready.
  - The beat is discarded and drop_cnt increments by the number of beats drained that cycle, saturating at 16'hFFFF.
- Pass-through: out_error = in_error of the beat OR watchdog/SOP-violation error. out_empty is passed through except on truncation. out_feed_id = grant.
- Simultaneous events: an EOP accept and a new SOP on another feed in the same cycle are not granted together; the new SOP is arbitrated the next cycle.

Test Plan:
- Feeds 0–3 each present one 3-beat message at once, out_ready=1 -> output order feeds 0,1,2,3; 12 beats with no gaps; out_feed_id 0,0,0,1,1,1,...
- Feed 1 streams continuously while feed 2 waits -> grants alternate 1,2,1,2 per message; no beat from feed 2 appears inside a feed-1 message.
- Feed 0 sends a 5-beat message with no EOP -> beat 4 output with eop=1, error=1, empty=0; trunc_cnt=1; beat 5 dropped, drop_cnt=1.
- During a feed-0 message, out_ready is toggled 1,0,0,1 -> out_* held stable while stalled; no beat lost or duplicated; in_ready[0]=0 only when out_valid & !out_ready.
- Feed 3 presents 2 non-SOP beats while idle -> in_ready[3]=1 for both; drop_cnt=2; out_valid stays 0.
- reset_n asserted mid-message -> outputs 0 immediately (asynchronous); after release feed 0 wins first arbitration.
